// File: rtl/mem_replay_engine.sv
// Memory-to-FIFO replay engine: replays an address window for N passes (or until
// stopped), tracking in-flight reads with credits so that returned words are never dropped.
module mem_replay_engine #(
   parameter int FIFO_DATA_WIDTH    = 120,
   parameter int MEM_ADDR_WIDTH     = 19,
   parameter int MEM_DATA_WIDTH     = 144,
   parameter int REPLAY_COUNT_WIDTH = 32,
   parameter int MAX_OUTSTANDING    = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          sw_rst,
   input  logic                          cal_done,
   input  logic                          start,
   input  logic                          stop,
   input  logic                          loop_forever,
   input  logic [REPLAY_COUNT_WIDTH-1:0] replay_count_cfg,
   input  logic [MEM_ADDR_WIDTH-1:0]     addr_low,
   input  logic [MEM_ADDR_WIDTH-1:0]     addr_high,
   output logic                          app_rd_cmd,
   output logic [MEM_ADDR_WIDTH-1:0]     app_rd_addr,
   input  logic                          app_rd_rdy,
   input  logic [MEM_DATA_WIDTH-1:0]     app_rd_data,
   input  logic                          app_rd_valid,
   output logic                          fifo_wr_en,
   output logic [FIFO_DATA_WIDTH-1:0]    fifo_data,
   input  logic                          fifo_nearly_full,
   output logic                          busy,
   output logic                          done,
   output logic                          cfg_err,
   output logic                          rsp_err,
   output logic [REPLAY_COUNT_WIDTH-1:0] passes_done,
   output logic [31:0]                   words_sent
);

   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                          state, state_nx;
   logic [MEM_ADDR_WIDTH-1:0]       addr, lo, hi;
   logic [REPLAY_COUNT_WIDTH-1:0]   count;
   logic                            loop_q;
   logic [OW-1:0]                   outst;
   logic                            stop_pend;
   logic                            held;
   logic                            srst;
   logic                            stop_now;
   logic                            issue_ok;
   logic                            accept;
   logic                            wrap;
   logic                            last_pass;
   logic                            expected;
   logic                            cfg_bad;
   logic                            start_ok;
   logic                            unused_data;

   assign srst        = rst | sw_rst;
   assign unused_data = ^app_rd_data;

   always_comb begin
      // A stop arriving this cycle already blocks a fresh command from rising.
      stop_now   = stop_pend || (stop && state == RUN);
      issue_ok   = cal_done && !fifo_nearly_full && (outst < OW'(MAX_OUTSTANDING)) && !stop_now;
      app_rd_cmd = (state == RUN) && (held || issue_ok);
      accept     = app_rd_cmd && app_rd_rdy;
      wrap       = (addr == hi);
      last_pass  = wrap && !loop_q && ((passes_done + REPLAY_COUNT_WIDTH'(1)) == count);
      expected   = app_rd_valid && (outst != '0);
      cfg_bad    = (addr_low > addr_high) || ((replay_count_cfg == '0) && !loop_forever);
      start_ok   = start && (state == IDLE || state == DONE);
      busy       = (state == RUN) || (state == DRAIN);
      done       = (state == DONE);
      app_rd_addr = addr;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: begin
            if (start) state_nx = cfg_bad ? DONE : RUN;
         end
         RUN: begin
            if ((accept && (last_pass || stop_now)) || (stop_now && !held)) state_nx = DRAIN;
         end
         DRAIN: begin
            if ((outst == '0) || ((outst == OW'(1)) && expected)) state_nx = DONE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state       <= IDLE;
         addr        <= '0;
         lo          <= '0;
         hi          <= '0;
         count       <= '0;
         loop_q      <= 1'b0;
         outst       <= '0;
         stop_pend   <= 1'b0;
         held        <= 1'b0;
         fifo_wr_en  <= 1'b0;
         fifo_data   <= '0;
         cfg_err     <= 1'b0;
         rsp_err     <= 1'b0;
         passes_done <= '0;
         words_sent  <= '0;
      end else begin
         state      <= state_nx;
         held       <= app_rd_cmd && !app_rd_rdy;
         fifo_wr_en <= expected;
         fifo_data  <= expected ? app_rd_data[FIFO_DATA_WIDTH-1:0] : '0;
         words_sent <= words_sent + 32'(expected);

         case ({accept, expected})
            2'b10:   outst <= outst + OW'(1);
            2'b01:   outst <= outst - OW'(1);
            default: outst <= outst;
         endcase

         if (app_rd_valid && outst == '0) rsp_err <= 1'b1;
         if (stop && state == RUN) stop_pend <= 1'b1;

         if (accept) begin
            if (wrap) begin
               addr        <= lo;
               passes_done <= passes_done + REPLAY_COUNT_WIDTH'(1);
            end else begin
               addr <= addr + MEM_ADDR_WIDTH'(1);
            end
         end

         if (start_ok) begin
            lo          <= addr_low;
            hi          <= addr_high;
            count       <= replay_count_cfg;
            loop_q      <= loop_forever;
            addr        <= addr_low;
            stop_pend   <= 1'b0;
            passes_done <= '0;
            words_sent  <= '0;
            rsp_err     <= 1'b0;
            cfg_err     <= cfg_bad;
         end
      end
   end

endmodule

// File: tb/tb_mem_replay_engine.sv
// Self-checking bench for mem_replay_engine: in-order memory model with programmable
// latency, protocol monitor, and a window/pass reference model of the expected reads.
module tb_mem_replay_engine;

   localparam int FW = 120;
   localparam int AW = 19;
   localparam int DW = 144;
   localparam int RW = 32;
   localparam int MO = 4;

   logic          clk, rst, sw_rst, cal_done, start, stop, loop_forever;
   logic [RW-1:0] replay_count_cfg;
   logic [AW-1:0] addr_low, addr_high, app_rd_addr;
   logic          app_rd_cmd, app_rd_rdy, app_rd_valid;
   logic [DW-1:0] app_rd_data;
   logic          fifo_wr_en, fifo_nearly_full, busy, done, cfg_err, rsp_err;
   logic [FW-1:0] fifo_data;
   logic [RW-1:0] passes_done;
   logic [31:0]   words_sent;

   mem_replay_engine #(
      .FIFO_DATA_WIDTH(FW), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW),
      .REPLAY_COUNT_WIDTH(RW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk), .rst(rst), .sw_rst(sw_rst), .cal_done(cal_done), .start(start), .stop(stop),
      .loop_forever(loop_forever), .replay_count_cfg(replay_count_cfg),
      .addr_low(addr_low), .addr_high(addr_high), .app_rd_cmd(app_rd_cmd),
      .app_rd_addr(app_rd_addr), .app_rd_rdy(app_rd_rdy), .app_rd_data(app_rd_data),
      .app_rd_valid(app_rd_valid), .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data),
      .fifo_nearly_full(fifo_nearly_full), .busy(busy), .done(done), .cfg_err(cfg_err),
      .rsp_err(rsp_err), .passes_done(passes_done), .words_sent(words_sent)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [AW-1:0] a;
      int            due;
   } rsp_t;

   rsp_t          mq[$];
   logic [AW-1:0] acc_q[$];
   logic [FW-1:0] wr_q[$];
   int            cyc = 0;
   int            lat = 3;
   int            rdy_mode = 0;  // 0: always ready, 1: random, 2: never
   int            cal_mode = 0;  // 0: calibrated, 1: random drop-outs
   int            nf_mode = 0;   // 0: driven by test, 1: random
   int            n_acc = 0, n_ret = 0, peak = 0, viol = 0;
   bit            prev_held = 1'b0;
   logic [AW-1:0] prev_addr = '0;

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      logic [31:0] x;
      x = 32'(a);
      return {x * 32'h9E3779B1, x ^ 32'h5A5A5A5A, x * 32'h85EBCA6B, x + 32'h01234567, x[15:0]};
   endfunction

   // Memory model: drives ready / returns just after each rising edge.
   always @(posedge clk) begin
      rsp_t r;
      cyc = cyc + 1;
      #1;
      app_rd_rdy   = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      cal_done     = (cal_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (nf_mode == 1) fifo_nearly_full = ($urandom_range(0, 3) == 0);
      app_rd_valid = 1'b0;
      app_rd_data  = '0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         r = mq.pop_front();
         app_rd_valid = 1'b1;
         app_rd_data  = mem_word(r.a);
         n_ret = n_ret + 1;
      end
   end

   // Monitor: records accepts and FIFO writes, counts protocol violations.
   always @(negedge clk) begin
      if (rst || sw_rst) begin
         prev_held = 1'b0;
      end else begin
         if (prev_held && (app_rd_cmd !== 1'b1 || app_rd_addr !== prev_addr)) viol = viol + 1;
         if (app_rd_cmd === 1'b1 && !prev_held && (!cal_done || fifo_nearly_full)) viol = viol + 1;
         if (app_rd_cmd === 1'b1 && busy !== 1'b1) viol = viol + 1;
         if (app_rd_cmd === 1'b1 && app_rd_rdy) begin
            acc_q.push_back(app_rd_addr);
            mq.push_back('{a: app_rd_addr, due: cyc + lat});
            n_acc = n_acc + 1;
         end
         prev_held = (app_rd_cmd === 1'b1) && !app_rd_rdy;
         prev_addr = app_rd_addr;
      end
      if (fifo_wr_en === 1'b1) wr_q.push_back(fifo_data);
      else if (fifo_data != '0) viol = viol + 1;
      if (n_acc - n_ret > peak) peak = n_acc - n_ret;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic do_start(input int lo, input int hi, input int cnt, input bit lp);
      @(posedge clk);
      #1;
      addr_low = AW'(lo);
      addr_high = AW'(hi);
      replay_count_cfg = RW'(cnt);
      loop_forever = lp;
      start = 1'b1;
      acc_q.delete();
      wr_q.delete();
      n_acc = 0;
      n_ret = 0;
      peak = 0;
      viol = 0;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      for (int k = 0; k < budget; k++) begin
         sample();
         if (done === 1'b1) break;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s done_timeout: done=%b after %0d cycles, want 1", name, done, budget);
      end
   endtask

   task automatic wait_acc(input string name, input int target);
      for (int k = 0; k < 200 && n_acc < target; k++) sample();
      checks++;
      if (n_acc < target) begin
         errors++;
         $display("FAIL %s accept_timeout: accepts=%0d want %0d", name, n_acc, target);
      end
   endtask

   // Reference: n accepts walking lo..hi cyclically, data in accept order.
   task automatic check_run(input string name, input int n, input int lo, input int hi);
      int win, bad_a, bad_d;
      logic [DW-1:0] w;
      win = hi - lo + 1;
      bad_a = 0;
      bad_d = 0;
      for (int i = 0; i < acc_q.size() && i < n; i++)
         if (acc_q[i] !== AW'(lo + (i % win))) bad_a++;
      for (int i = 0; i < wr_q.size() && i < n; i++) begin
         w = mem_word(AW'(lo + (i % win)));
         if (wr_q[i] !== w[FW-1:0]) bad_d++;
      end
      checks++;
      if (acc_q.size() != n || bad_a != 0) begin
         errors++;
         $display("FAIL %s addr_seq: got %0d accepts (%0d wrong), want %0d", name, acc_q.size(), bad_a, n);
      end
      checks++;
      if (wr_q.size() != n || bad_d != 0) begin
         errors++;
         $display("FAIL %s fifo_seq: got %0d writes (%0d wrong), want %0d", name, wr_q.size(), bad_d, n);
      end
      checks++;
      if (passes_done !== RW'(n / win) || words_sent !== 32'(n)) begin
         errors++;
         $display("FAIL %s counters: passes=%0d words=%0d, want %0d %0d", name, passes_done, words_sent, n / win, n);
      end
      checks++;
      if (rsp_err !== 1'b0 || cfg_err !== 1'b0 || busy !== 1'b0 || viol != 0) begin
         errors++;
         $display("FAIL %s status: rsp_err=%b cfg_err=%b busy=%b viol=%0d, want 0 0 0 0", name, rsp_err, cfg_err, busy, viol);
      end
   endtask

   task automatic check_idle_zero(input string name);
      checks++;
      if ({app_rd_cmd, app_rd_addr, fifo_wr_en, fifo_data, busy, done, cfg_err, rsp_err} !== '0 ||
          passes_done !== '0 || words_sent !== '0) begin
         errors++;
         $display("FAIL %s outputs_zero: cmd=%b addr=%0d wr=%b busy=%b done=%b cfg=%b rsp=%b passes=%0d words=%0d, want all 0",
                  name, app_rd_cmd, app_rd_addr, fifo_wr_en, busy, done, cfg_err, rsp_err, passes_done, words_sent);
      end
   endtask

   task automatic test_reset();
      sample();
      check_idle_zero("reset");
   endtask

   task automatic test_basic();
      lat = 3;
      do_start(10, 13, 2, 1'b0);
      wait_done("basic", 200);
      check_run("basic", 8, 10, 13);
   endtask

   task automatic test_nearly_full();
      lat = 3;
      do_start(10, 13, 2, 1'b0);
      wait_acc("nearly_full", 2);
      @(posedge clk);
      #1;
      fifo_nearly_full = 1'b1;
      tick(12);
      sample();
      checks++;
      if (n_acc != 2 || wr_q.size() != 2 || busy !== 1'b1) begin
         errors++;
         $display("FAIL nearly_full hold: accepts=%0d writes=%0d busy=%b, want 2 2 1", n_acc, wr_q.size(), busy);
      end
      @(posedge clk);
      #1;
      fifo_nearly_full = 1'b0;
      wait_done("nearly_full", 200);
      check_run("nearly_full", 8, 10, 13);
   endtask

   task automatic test_outstanding();
      lat = 20;
      do_start(0, 9, 1, 1'b0);
      wait_done("outstanding", 600);
      checks++;
      if (peak != MO) begin
         errors++;
         $display("FAIL outstanding peak: got %0d want %0d", peak, MO);
      end
      check_run("outstanding", 10, 0, 9);
      lat = 3;
   endtask

   task automatic test_stop();
      lat = 3;
      rdy_mode = 0;
      do_start(5, 5, 0, 1'b1);
      wait_acc("stop", 7);
      rdy_mode = 2;
      tick(2);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      sample();
      checks++;
      if (app_rd_cmd !== 1'b1 || busy !== 1'b1 || n_acc != 7) begin
         errors++;
         $display("FAIL stop held_cmd: cmd=%b busy=%b accepts=%0d, want 1 1 7", app_rd_cmd, busy, n_acc);
      end
      rdy_mode = 0;
      wait_done("stop", 100);
      check_run("stop", 8, 5, 5);
   endtask

   task automatic test_cfg_err();
      do_start(20, 10, 1, 1'b0);
      tick(5);
      sample();
      checks++;
      if (cfg_err !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || n_acc != 0) begin
         errors++;
         $display("FAIL cfg_err window: cfg=%b done=%b busy=%b accepts=%0d, want 1 1 0 0", cfg_err, done, busy, n_acc);
      end
      do_start(3, 3, 0, 1'b0);
      tick(3);
      sample();
      checks++;
      if (cfg_err !== 1'b1 || done !== 1'b1 || n_acc != 0) begin
         errors++;
         $display("FAIL cfg_err zero_count: cfg=%b done=%b accepts=%0d, want 1 1 0", cfg_err, done, n_acc);
      end
      do_start(0, 2, 1, 1'b0);
      sample();
      checks++;
      if (cfg_err !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL cfg_err clear: cfg=%b done=%b, want 0 0", cfg_err, done);
      end
      wait_done("cfg_recover", 100);
      check_run("cfg_recover", 3, 0, 2);
   endtask

   task automatic test_mid_reset();
      lat = 10;
      do_start(0, 40, 1, 1'b0);
      wait_acc("mid_reset", 3);
      @(posedge clk);
      #1;
      fifo_nearly_full = 1'b1;
      tick(1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      fifo_nearly_full = 1'b0;
      sample();
      check_idle_zero("mid_reset");
      checks++;
      if (n_acc != 3) begin
         errors++;
         $display("FAIL mid_reset outstanding: accepts=%0d want 3", n_acc);
      end
      tick(15);
      sample();
      checks++;
      if (wr_q.size() != 0 || rsp_err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset late_returns: writes=%0d rsp_err=%b busy=%b, want 0 1 0", wr_q.size(), rsp_err, busy);
      end
      lat = 3;
      do_start(0, 3, 1, 1'b0);
      wait_done("after_reset", 100);
      check_run("after_reset", 4, 0, 3);
   endtask

   task automatic test_sw_rst();
      lat = 6;
      do_start(0, 30, 1, 1'b0);
      tick(4);
      sw_rst = 1'b1;
      tick(1);
      sw_rst = 1'b0;
      sample();
      check_idle_zero("sw_rst");
      wr_q.delete();
      tick(12);
      sample();
      checks++;
      if (wr_q.size() != 0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL sw_rst idle: writes=%0d busy=%b done=%b, want 0 0 0", wr_q.size(), busy, done);
      end
      lat = 3;
   endtask

   task automatic test_random();
      int lo, hi, cnt, n;
      for (int it = 0; it < 8; it++) begin
         lo  = int'($urandom_range(0, 60));
         hi  = lo + int'($urandom_range(0, 5));
         cnt = int'($urandom_range(1, 3));
         lat = int'($urandom_range(1, 8));
         rdy_mode = 1;
         cal_mode = 1;
         nf_mode  = 1;
         if (it == 7) begin
            do_start(lo, hi, 0, 1'b1);
            tick(int'($urandom_range(20, 60)));
            stop = 1'b1;
            tick(1);
            stop = 1'b0;
            wait_done("random_stop", 400);
            n = acc_q.size();
         end else begin
            do_start(lo, hi, cnt, 1'b0);
            wait_done("random", 800);
            n = (hi - lo + 1) * cnt;
         end
         rdy_mode = 0;
         cal_mode = 0;
         nf_mode  = 0;
         fifo_nearly_full = 1'b0;
         sample();
         check_run((it == 7) ? "random_stop" : "random", n, lo, hi);
         checks++;
         if (peak > MO) begin
            errors++;
            $display("FAIL random peak: got %0d limit %0d", peak, MO);
         end
      end
      lat = 3;
   endtask

   initial begin
      rst = 1'b1;
      sw_rst = 1'b0;
      start = 1'b0;
      stop = 1'b0;
      loop_forever = 1'b0;
      replay_count_cfg = '0;
      addr_low = '0;
      addr_high = '0;
      fifo_nearly_full = 1'b0;
      cal_done = 1'b1;
      app_rd_rdy = 1'b1;
      app_rd_valid = 1'b0;
      app_rd_data = '0;
      tick(3);
      rst = 1'b0;
      test_reset();
      test_basic();
      test_nearly_full();
      test_outstanding();
      test_stop();
      test_cfg_err();
      test_mid_reset();
      test_sw_rst();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
